// File: rtl/sample0_acc_pkg.sv
// Shared defaults and helpers for the sample0 dot-product accumulator.
// Holds the output-register state enum and the clamp helpers used when
// saturation is enabled (SAMPLE0_ACC_SAT_EN).
package sample0_acc_pkg;

    localparam int PROD_W_DEF  = 14;
    localparam int MUL_LAT_DEF = 2;
    localparam int OUT_W_DEF   = 14;
    localparam int N_TERMS_DEF = 16;

    // Output register: EMPTY while no result is presented, HOLD while res_valid=1.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    // Clamp a signed value to the range of a w-bit two's-complement number.
    // Operands are carried at 64 bits, so the accumulator must be no wider.
    function automatic logic signed [63:0] clamp_to_width(input logic signed [63:0] v,
                                                          input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    // True when v cannot be represented as a w-bit two's-complement number.
    function automatic logic exceeds_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/sample0_valid_pipe.sv
// Validity shadow of the multiplier pipeline: a DEPTH-deep shift register of
// valid bits that advances only on clock-enable cycles, so bit DEPTH-1 tells
// whether the multiplier output currently holds a real product.
module sample0_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] vld_pipe_reg;
    logic [DEPTH-1:0] stage_in;

    // Each stage takes the previous stage's bit; stage 0 takes the new valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign stage_in[gi] = din;
        end else begin : g_rest
            assign stage_in[gi] = vld_pipe_reg[gi-1];
        end
    end

    // Shift on enabled cycles, hold otherwise; reset drops all in-flight valids.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe_reg <= '0;
        end else if (ce) begin
            vld_pipe_reg <= stage_in;
        end
    end

    assign dout = vld_pipe_reg[DEPTH-1];

endmodule

// File: rtl/sample0_dot_acc.sv
// Dot-product accumulator behind the sample0 multiplier: drives the
// multiplier clock enable, follows operand validity through its fixed
// latency, sums N_TERMS products and presents each sum on valid/ready.
// Optional macro SAMPLE0_ACC_SAT_EN: saturate the result to OUT_W bits and
// flag res_sat; without it the result wraps and res_sat stays 0.
module sample0_dot_acc
    import sample0_acc_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    mul_ce,
    input  logic [PROD_W-1:0]       prod_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [OUT_W-1:0] res_data,
    output logic                    res_sat
);

    // Wide enough that N_TERMS full-scale products cannot overflow.
    localparam int ACC_W = PROD_W + $clog2(N_TERMS);
    localparam int CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

    out_state_e              out_state_reg, out_state_next;
    logic [CNT_W-1:0]        term_cnt_reg, term_cnt_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic signed [OUT_W-1:0] res_data_reg, res_data_next;
    logic                    res_sat_reg, res_sat_next;

    logic                    accept;
    logic                    prod_vld;
    logic                    prod_fire;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [OUT_W-1:0] fit_data;
    logic                    fit_sat;

    // The whole pipeline advances only when the output slot is free or draining.
    assign mul_ce   = (out_state_reg != OUT_HOLD) || res_ready;
    assign in_ready = mul_ce;
    assign accept   = in_valid && in_ready;

    sample0_valid_pipe #(
        .DEPTH (MUL_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .reset (reset),
        .ce    (mul_ce),
        .din   (accept),
        .dout  (prod_vld)
    );

    // A product counts only on an advancing cycle whose slot carried a real pair.
    assign prod_fire = mul_ce && prod_vld;

    // First term loads rather than adds, so no separate clear cycle is needed.
    assign acc_base = (term_cnt_reg == '0) ? '0 : acc_reg;
    assign prod_ext = ACC_W'($signed(prod_in));
    assign acc_sum  = acc_base + prod_ext;

`ifdef SAMPLE0_ACC_SAT_EN
    assign fit_data = OUT_W'(clamp_to_width(64'(acc_sum), OUT_W));
    assign fit_sat  = exceeds_width(64'(acc_sum), OUT_W);
`else
    assign fit_data = OUT_W'(acc_sum);
    assign fit_sat  = 1'b0;
`endif

    // Next-state: drain the held result, then accumulate or finish a vector.
    always_comb begin
        out_state_next = out_state_reg;
        term_cnt_next  = term_cnt_reg;
        acc_next       = acc_reg;
        res_data_next  = res_data_reg;
        res_sat_next   = res_sat_reg;

        if ((out_state_reg == OUT_HOLD) && res_ready) begin
            out_state_next = OUT_EMPTY;
        end

        // A completing sum on the drain edge overrides the drain and stays held.
        if (prod_fire) begin
            if (term_cnt_reg == LAST_TERM) begin
                term_cnt_next  = '0;
                acc_next       = '0;
                res_data_next  = fit_data;
                res_sat_next   = fit_sat;
                out_state_next = OUT_HOLD;
            end else begin
                term_cnt_next = term_cnt_reg + CNT_W'(1);
                acc_next      = acc_sum;
            end
        end
    end

    // State registers; reset discards any partial vector and held result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_state_reg <= OUT_EMPTY;
            term_cnt_reg  <= '0;
            acc_reg       <= '0;
            res_data_reg  <= '0;
            res_sat_reg   <= 1'b0;
        end else begin
            out_state_reg <= out_state_next;
            term_cnt_reg  <= term_cnt_next;
            acc_reg       <= acc_next;
            res_data_reg  <= res_data_next;
            res_sat_reg   <= res_sat_next;
        end
    end

    assign res_valid = (out_state_reg == OUT_HOLD);
    assign res_data  = res_data_reg;
    assign res_sat   = res_sat_reg;

endmodule
